// File: rtl/fsk_fword_gen.sv
// FSK frequency-word generator: queues 1-bit symbols and drives the DDS FWORD with
// the mark/space word for one programmable period each. Optional macro: FSK_SLEW_EN.
module fsk_fword_gen #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PW        = 24,
    parameter logic [31:0] SLEW_STEP = 32'h0000_1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_data,
    input  logic [31:0]              fword_mark,
    input  logic [31:0]              fword_space,
    input  logic [31:0]              fword_idle,
    input  logic [PW-1:0]            sym_period,
    output logic [31:0]              fword,
    output logic                     tx_active,
    output logic                     sym_tick,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned FW = 32;

    // A zero slew step would never converge, so it is rejected in every build.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PW < 1 || SLEW_STEP == '0) begin : g_bad_cfg
        $error("fsk_fword_gen: unsupported parameter set");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    state_e          state_q;
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [LW-1:0]   level_q;
    logic [PW-1:0]   cnt_q;
    logic [FW-1:0]   tgt_q;
    logic            tx_active_q;
    logic            sym_tick_q;
    logic            done_q;

    logic            s_ready_c;
    logic            push_c;
    logic            start_c;
    logic            next_c;
    logic            pop_c;
    logic [FW-1:0]   sel_word_c;
    logic [PW-1:0]   reload_c;

    // Handshake, pop decisions and the word/period picked for the next symbol.
    always_comb begin
        s_ready_c  = (level_q != LW'(DEPTH));
        push_c     = s_valid && s_ready_c && !flush;
        start_c    = (state_q == S_IDLE) && en && (level_q != '0) && !flush;
        next_c     = (state_q == S_SEND) && (cnt_q == '0) && en && (level_q != '0);
        pop_c      = start_c || next_c;
        sel_word_c = mem_q[rd_ptr_q] ? fword_mark : fword_space;
        reload_c   = (sym_period == '0) ? '0 : sym_period - PW'(1);
    end

    // Symbol storage has no reset; its contents are meaningless once level is zero.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + LW'(push_c) - LW'(pop_c);
        end
    end

    // Keying FSM: IDLE tracks the idle word, SEND holds each symbol for its period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tgt_q       <= '0;
            tx_active_q <= 1'b0;
            sym_tick_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sym_tick_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tgt_q <= fword_idle;
                    if (start_c) begin
                        tgt_q       <= sel_word_c;
                        cnt_q       <= reload_c;
                        sym_tick_q  <= 1'b1;
                        tx_active_q <= 1'b1;
                        state_q     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - PW'(1);
                    end else if (next_c) begin
                        tgt_q      <= sel_word_c;
                        cnt_q      <= reload_c;
                        sym_tick_q <= 1'b1;
                    end else begin
                        tgt_q       <= fword_idle;
                        tx_active_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FSK_SLEW_EN
    logic [FW-1:0] fword_q;

    // Walk toward the target in SLEW_STEP increments, landing exactly on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fword_q <= '0;
        end else if (tgt_q >= fword_q) begin
            fword_q <= ((tgt_q - fword_q) <= SLEW_STEP) ? tgt_q : fword_q + SLEW_STEP;
        end else begin
            fword_q <= ((fword_q - tgt_q) <= SLEW_STEP) ? tgt_q : fword_q - SLEW_STEP;
        end
    end

    assign fword = fword_q;
`else
    assign fword = tgt_q;
`endif

    assign s_ready   = s_ready_c;
    assign tx_active = tx_active_q;
    assign sym_tick  = sym_tick_q;
    assign done      = done_q;
    assign level     = level_q;

endmodule

// File: tb/tb_fsk_fword_gen.sv
// Directed bench for fsk_fword_gen (default build): reset, message timing, full FIFO,
// en drop, zero period, flush and async reset; inputs driven and outputs sampled on negedge.
module tb_fsk_fword_gen;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 24;
    localparam logic [31:0] IDLE  = 32'h0100_0000;
    localparam logic [31:0] MARK  = 32'h0200_0000;
    localparam logic [31:0] SPACE = 32'h0180_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic        s_data;
    logic [31:0] fword_mark;
    logic [31:0] fword_space;
    logic [31:0] fword_idle;
    logic [PW-1:0] sym_period;
    logic [31:0] fword;
    logic        tx_active;
    logic        sym_tick;
    logic        done;
    logic [4:0]  level;

    int vecs = 0;
    int errs = 0;

    fsk_fword_gen #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fword_mark(fword_mark), .fword_space(fword_space), .fword_idle(fword_idle),
        .sym_period(sym_period), .fword(fword), .tx_active(tx_active),
        .sym_tick(sym_tick), .done(done), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic bit_v);
        s_valid = 1'b1;
        s_data  = bit_v;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    initial begin
        logic pat [17];
        int   ticks;
        int   dones;
        int   idx;

        rst_n = 1'b0; en = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = 1'b0;
        fword_mark = MARK; fword_space = SPACE; fword_idle = IDLE; sym_period = PW'(4);

        // Reset values, then idle word one cycle after release.
        repeat (3) @(negedge clk);
        check("rst_fword", fword, 32'h0);
        check("rst_tx", 32'(tx_active), 32'h0);
        check("rst_tick", 32'(sym_tick), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_ready", 32'(s_ready), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_word", fword, IDLE);
        fword_idle = 32'h0111_0000;
        @(negedge clk);
        check("idle_track", fword, 32'h0111_0000);
        fword_idle = IDLE;
        @(negedge clk);

        // Message 1,0,1 with period 4.
        push(1'b1); push(1'b0); push(1'b1);
        check("msg_level", 32'(level), 32'd3);
        en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("msg_fword_%0d", k), fword,
                  (k <= 4) ? MARK : (k <= 8) ? SPACE : (k <= 12) ? MARK : IDLE);
            check($sformatf("msg_tick_%0d", k), 32'(sym_tick),
                  32'((k == 1) || (k == 5) || (k == 9)));
            check($sformatf("msg_tx_%0d", k), 32'(tx_active), 32'(k <= 12));
            check($sformatf("msg_done_%0d", k), 32'(done), 32'(k == 13));
        end
        en = 1'b0;
        check("msg_level_end", 32'(level), 32'd0);

        // Fill the FIFO, 17th push must be ignored, then send with period 2.
        sym_period = PW'(2);
        for (int k = 0; k < 17; k++) begin
            pat[k] = (k % 3 == 0);
            if (k == 16) begin
                check("full_ready", 32'(s_ready), 32'h0);
                check("full_level", 32'(level), 32'd16);
            end
            push(pat[k]);
        end
        check("full_level_after", 32'(level), 32'd16);
        en = 1'b1;
        ticks = 0; dones = 0; idx = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (sym_tick) begin
                if (idx < 16) begin
                    check($sformatf("full_sym_%0d", idx), fword, pat[idx] ? MARK : SPACE);
                end
                idx++;
                ticks++;
            end
            if (done) dones++;
        end
        en = 1'b0;
        check("full_ticks", 32'(ticks), 32'd16);
        check("full_dones", 32'(dones), 32'd1);
        check("full_level_end", 32'(level), 32'd0);
        check("full_idle", fword, IDLE);

        // Drop en mid-symbol: symbol completes, remaining four stay queued.
        sym_period = PW'(10);
        push(1'b1); push(1'b1); push(1'b0); push(1'b1); push(1'b0);
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("drop_fword_%0d", k), fword, (k <= 10) ? MARK : IDLE);
            check($sformatf("drop_tx_%0d", k), 32'(tx_active), 32'(k <= 10));
            check($sformatf("drop_tick_%0d", k), 32'(sym_tick), 32'(k == 1));
            check($sformatf("drop_done_%0d", k), 32'(done), 32'(k == 11));
            if (k == 3) en = 1'b0;
        end
        check("drop_level", 32'(level), 32'd4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle_level", 32'(level), 32'd0);

        // Zero period behaves as one cycle per symbol.
        sym_period = '0;
        push(1'b1); push(1'b0);
        en = 1'b1;
        @(negedge clk);
        check("zp_w1", fword, MARK);
        check("zp_t1", 32'(sym_tick), 32'h1);
        @(negedge clk);
        check("zp_w2", fword, SPACE);
        check("zp_t2", 32'(sym_tick), 32'h1);
        @(negedge clk);
        check("zp_w3", fword, IDLE);
        check("zp_done", 32'(done), 32'h1);
        check("zp_tx", 32'(tx_active), 32'h0);
        en = 1'b0;

        // Flush (with a simultaneous push) during symbol 1 of 3.
        sym_period = PW'(4);
        push(1'b0); push(1'b1); push(1'b1);
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("fl_fword_%0d", k), fword, (k <= 4) ? SPACE : IDLE);
            check($sformatf("fl_done_%0d", k), 32'(done), 32'(k == 5));
            if (k == 1) check("fl_level_pre", 32'(level), 32'd2);
            if (k == 3) check("fl_level_post", 32'(level), 32'd0);
            flush   = (k == 2);
            s_valid = (k == 2);
            s_data  = 1'b1;
        end
        s_valid = 1'b0;
        en = 1'b0;

        // Asynchronous reset in the middle of a symbol.
        sym_period = PW'(8);
        push(1'b1); push(1'b0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("ar_pre", fword, MARK);
        rst_n = 1'b0;
        #1;
        check("ar_fword", fword, 32'h0);
        check("ar_tx", 32'(tx_active), 32'h0);
        check("ar_level", 32'(level), 32'h0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_idle", fword, IDLE);
        check("ar_level_after", 32'(level), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
